// File: rtl/ama_riscv_retire_tracker_pkg.sv
// Shared types for the retire tracker: per-stage sideband, trace record, counter slots.
// Address fields are sized for RV64 so one record layout serves any ARCH_W <= 64.
package ama_riscv_trace_pkg;

  localparam int TRACE_AW = 64;

  // dmem_size: 0..3 = lb..ld, 4..7 = sb..sd, 8 = no dmem access
  localparam logic [3:0] DMEM_SIZE_NA = 4'd8;

  localparam int CNT_RETIRED  = 0;
  localparam int CNT_BRANCHES = 1;
  localparam int CNT_TAKEN    = 2;
  localparam int CNT_BP_HITS  = 3;
  localparam int CNT_LOADS    = 4;
  localparam int CNT_STORES   = 5;
  localparam int CNT_BUBBLES  = 6;
  localparam int CNT_DROPPED  = 7;
  localparam int CNT_NUM      = 8;

  typedef struct packed {
    logic [31:0]         inst;
    logic [TRACE_AW-1:0] pc;
    logic                branch;
    logic                taken;
    logic                bp_hit;
    logic [TRACE_AW-1:0] dmem_addr;
    logic [3:0]          dmem_size;
  } trace_rec_t;

  typedef struct packed {
    logic                branch;
    logic                taken;
    logic                bp_hit;
    logic [TRACE_AW-1:0] dmem_addr;
    logic [3:0]          dmem_size;
    logic                bubble;
  } stage_side_t;

  function automatic stage_side_t side_empty(input logic bubble);
    stage_side_t s;
    s           = '0;
    s.dmem_size = DMEM_SIZE_NA;
    s.bubble    = bubble;
    return s;
  endfunction

endpackage

// File: rtl/ama_riscv_retire_tracker_if.sv
// Trace record stream: valid/ready, record held stable while stalled.
interface ama_riscv_retire_tracker_if;
  import ama_riscv_trace_pkg::*;

  logic       trace_valid;
  logic       trace_ready;
  trace_rec_t trace_rec;

  modport master (output trace_valid, output trace_rec, input trace_ready);
  modport slave  (input trace_valid, input trace_rec, output trace_ready);
endinterface

// File: rtl/ama_riscv_retire_tracker_fifo.sv
// Generic synchronous FIFO; head entry visible the cycle after it is written.
// Latency: 1 cycle write-to-head. Backpressure: push while full is ignored
// unless a pop happens in the same cycle, in which case both take effect.
module ama_riscv_trace_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     push_dat,
  input  logic pop,
  output T     head_dat,
  output logic full,
  output logic empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop & ~empty;
  // When full, a simultaneous pop frees the slot the push writes into
  assign do_push  = push & (~full | do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/ama_riscv_retire_tracker.sv
// Carries EXE sideband to retirement, emits trace records, keeps saturating event counters.
// Latency: NUM_STAGES stage registers EXE->RET, +1 cycle retire-to-trace_valid.
// Backpressure: FIFO_DEPTH-entry buffer; retirement into a full, unpopped buffer drops the record.
module ama_riscv_retire_tracker
  import ama_riscv_trace_pkg::*;
#(
  parameter int NUM_STAGES    = 3,  // 2..6
  parameter int RESOLVE_STAGE = 1,  // 0..NUM_STAGES-1
  parameter int FIFO_DEPTH    = 4,  // power of 2, >= 2
  parameter int CNT_W         = 32,
  parameter int ARCH_W        = 32  // <= TRACE_AW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_STAGES-1:0]   stage_en,
  input  logic [NUM_STAGES-1:0]   stage_flush,
  input  logic                    exe_branch,
  input  logic                    exe_dmem_valid,
  input  logic [ARCH_W-1:0]       exe_dmem_addr,
  input  logic                    exe_dmem_store,
  input  logic [1:0]              exe_dmem_dtype,
  input  logic                    res_branch_taken,
  input  logic                    res_bp_hit,
  input  logic                    inst_retired,
  input  logic [31:0]             ret_inst,
  input  logic [ARCH_W-1:0]       ret_pc,
  ama_riscv_retire_tracker_if.master trace,
  input  logic                    cnt_clear,
  output logic [CNT_NUM*CNT_W-1:0] cnt_bus,
  output logic                    overflow
);

  // pipe[0] is the EXE-side input, pipe[i+1] the output of stage register i
  stage_side_t pipe [NUM_STAGES+1];
  logic        last_bubble_d;

  always_comb begin
    pipe[0]        = side_empty(1'b0);
    pipe[0].branch = exe_branch;
    if (exe_dmem_valid) begin
      pipe[0].dmem_addr = TRACE_AW'(exe_dmem_addr);
      pipe[0].dmem_size = {1'b0, exe_dmem_store, exe_dmem_dtype};
    end
  end

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    stage_side_t d;
    stage_side_t q;

    always_comb begin
      d = pipe[i];
      if (i == RESOLVE_STAGE) begin
        d.taken  = res_branch_taken & pipe[i].branch;
        d.bp_hit = res_bp_hit & pipe[i].branch;
      end
      if (stage_flush[i]) d = side_empty(1'b1);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)              q <= side_empty(1'b0);
      else if (stage_en[i]) q <= d;
    end

    assign pipe[i+1] = q;

    if (i == NUM_STAGES-1) begin : g_last
      assign last_bubble_d = d.bubble;
    end
  end

  trace_rec_t ret_rec;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;
  logic       fifo_drop;

  always_comb begin
    ret_rec           = '0;
    ret_rec.inst      = ret_inst;
    ret_rec.pc        = TRACE_AW'(ret_pc);
    ret_rec.branch    = pipe[NUM_STAGES].branch;
    ret_rec.taken     = pipe[NUM_STAGES].taken;
    ret_rec.bp_hit    = pipe[NUM_STAGES].bp_hit;
    ret_rec.dmem_addr = pipe[NUM_STAGES].dmem_addr;
    ret_rec.dmem_size = pipe[NUM_STAGES].dmem_size;
  end

  assign fifo_pop          = trace.trace_valid & trace.trace_ready;
  assign fifo_drop         = inst_retired & fifo_full & ~fifo_pop;
  assign trace.trace_valid = ~fifo_empty;

  ama_riscv_trace_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (trace_rec_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (inst_retired),
    .push_dat (ret_rec),
    .pop      (fifo_pop),
    .head_dat (trace.trace_rec),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            overflow <= 1'b0;
    else if (fifo_drop) overflow <= 1'b1;
  end

  logic [CNT_NUM-1:0] inc;

  always_comb begin
    inc               = '0;
    inc[CNT_RETIRED]  = inst_retired;
    inc[CNT_BRANCHES] = inst_retired & pipe[NUM_STAGES].branch;
    inc[CNT_TAKEN]    = inst_retired & pipe[NUM_STAGES].taken;
    inc[CNT_BP_HITS]  = inst_retired & pipe[NUM_STAGES].bp_hit;
    inc[CNT_LOADS]    = inst_retired & (pipe[NUM_STAGES].dmem_size < 4'd4);
    inc[CNT_STORES]   = inst_retired & (pipe[NUM_STAGES].dmem_size[3:2] == 2'b01);
    inc[CNT_BUBBLES]  = ~inst_retired & stage_en[NUM_STAGES-1] & last_bubble_d;
    inc[CNT_DROPPED]  = fifo_drop;
  end

  for (genvar k = 0; k < CNT_NUM; k++) begin : g_cnt
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)            cnt <= '0;
      else if (cnt_clear) cnt <= '0;
      else if (inc[k] && (cnt != {CNT_W{1'b1}})) cnt <= cnt + CNT_W'(1);
    end

    assign cnt_bus[k*CNT_W +: CNT_W] = cnt;
  end

endmodule
